// File: rtl/lsu_mem_if.sv
// Load/store front-end for the data port of a sync RAM: request decode, lane steering,
// load alignment/extension and a valid/ready handshake over the 1-cycle read latency.
module lsu_mem_if #(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_misaligned,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_we,
  output logic [3:0]            d_be,
  output logic [31:0]           d_wdata,
  input  logic [31:0]           d_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;

  logic        accept;
  logic        misaligned;
  logic [1:0]  off;
  logic        do_store;
  logic [31:0] load_data;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign off       = req_addr[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  assign do_store = accept & req_we & ~misaligned;

  // RAM port is driven straight from the request so the RAM samples it on the accept edge
  always_comb begin
    d_addr  = accept ? req_addr[ADDR_WIDTH+1:2] : addr_q;
    d_we    = do_store;
    d_be    = '0;
    d_wdata = '0;
    if (do_store) begin
      case (req_size)
        2'b00: begin
          d_be    = 4'b0001 << off;
          d_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          d_be    = 4'b0011 << off;
          d_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          d_be    = 4'hF;
          d_wdata = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    sel_b     = d_rdata[{off_q, 3'b000} +: 8];
    sel_h     = d_rdata[{off_q[1], 4'b0000} +: 16];
    load_data = d_rdata;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   load_data = uns_q ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: load_data = d_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr[ADDR_WIDTH+1:2];
            off_q  <= off;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            if (misaligned || req_we) begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_rdata      <= '0;
              rsp_misaligned <= misaligned;
            end else begin
              state <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          state          <= RESP;
          rsp_valid      <= 1'b1;
          rsp_rdata      <= load_data;
          rsp_misaligned <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a small behavioural sync RAM on the data port.
module tb_lsu_mem_if;

  localparam int unsigned AW = 15;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_misaligned;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;

  logic [31:0] mem [256];

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned rsp_count;

  lsu_mem_if #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .d_addr         (d_addr),
    .d_we           (d_we),
    .d_be           (d_be),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: byte-enabled write, registered read
  always @(posedge clk) begin
    if (d_we) begin
      for (int i = 0; i < 4; i++) begin
        if (d_be[i]) mem[d_addr[7:0]][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
    d_rdata <= mem[d_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // One request from IDLE through its response; returns at IDLE.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [AW+1:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic exp_mis, input logic [31:0] exp_rdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, " d_addr"}, {17'h0, d_addr}, {17'h0, addr[AW+1:2]});
    check({tag, " d_we"}, {31'h0, d_we}, {31'h0, we & ~exp_mis});
    check({tag, " d_be"}, {28'h0, d_be}, {28'h0, exp_be});
    check({tag, " d_wdata"}, d_wdata, exp_wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = '1;
    check({tag, " ready T+1"}, {31'h0, req_ready}, 32'h0);
    if (!we && !exp_mis) begin
      check({tag, " no rsp T+1"}, {31'h0, rsp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, " misaligned"}, {31'h0, rsp_misaligned}, {31'h0, exp_mis});
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    @(posedge clk); #1;
    check({tag, " rsp pulse"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rsp_count = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {31'h0, req_ready}, 32'h1);
    check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst rdata", rsp_rdata, 32'h0);
    check("rst mis", {31'h0, rsp_misaligned}, 32'h0);
    check("rst d_we", {31'h0, d_we}, 32'h0);
    check("rst d_be", {28'h0, d_be}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    //        tag     we    size   uns  addr   wdata         be    wdata_exp    mis   rdata
    access("sw",    1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    access("sb",    1'b1, 2'b00, 1'b0, 'h13, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 1'b0, 32'h0);
    access("lw",    1'b0, 2'b10, 1'b0, 'h10, 32'h0,        4'h0, 32'h0,        1'b0, 32'hA5ADBEEF);
    access("lb13",  1'b0, 2'b00, 1'b0, 'h13, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFFFFA5);
    access("lbu13", 1'b0, 2'b00, 1'b1, 'h13, 32'h0,        4'h0, 32'h0,        1'b0, 32'h000000A5);
    access("lh12",  1'b0, 2'b01, 1'b0, 'h12, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFFA5AD);
    access("lhu12", 1'b0, 2'b01, 1'b1, 'h12, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0000A5AD);
    access("lb11",  1'b0, 2'b00, 1'b0, 'h11, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFFFFBE);
    access("lbu10", 1'b0, 2'b00, 1'b1, 'h10, 32'h0,        4'h0, 32'h0,        1'b0, 32'h000000EF);
    access("lh10",  1'b0, 2'b01, 1'b0, 'h10, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFFBEEF);
    access("sh16",  1'b1, 2'b01, 1'b0, 'h16, 32'hCAFE1234, 4'hC, 32'h12341234, 1'b0, 32'h0);
    access("lhu16", 1'b0, 2'b01, 1'b1, 'h16, 32'h0,        4'h0, 32'h0,        1'b0, 32'h00001234);
    access("sb15",  1'b1, 2'b00, 1'b0, 'h15, 32'h00000080, 4'h2, 32'h80808080, 1'b0, 32'h0);
    access("lw14",  1'b0, 2'b10, 1'b0, 'h14, 32'h0,        4'h0, 32'h0,        1'b0, 32'h12348000);
    access("lw11",  1'b0, 2'b10, 1'b0, 'h11, 32'h0,        4'h0, 32'h0,        1'b1, 32'h0);
    access("sh13",  1'b1, 2'b01, 1'b0, 'h13, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b1, 32'h0);
    access("sz11",  1'b1, 2'b11, 1'b0, 'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b1, 32'h0);
    access("lw10b", 1'b0, 2'b10, 1'b0, 'h10, 32'h0,        4'h0, 32'h0,        1'b0, 32'hA5ADBEEF);

    // Back-to-back loads with req_valid held high; address change in T+1 must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 'h10;
    #1; check("b2b ready T", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_addr = 'h14;
    check("b2b ready T+1", {31'h0, req_ready}, 32'h0);
    rsp_count += rsp_valid;
    @(posedge clk); #1;
    check("b2b ready T+2", {31'h0, req_ready}, 32'h0);
    check("b2b rsp1", {31'h0, rsp_valid}, 32'h1);
    check("b2b rdata1", rsp_rdata, 32'hA5ADBEEF);
    rsp_count += rsp_valid;
    @(posedge clk); #1;
    check("b2b ready T+3", {31'h0, req_ready}, 32'h1);
    check("b2b d_addr T+3", {17'h0, d_addr}, 32'h5);
    rsp_count += rsp_valid;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_count += rsp_valid;
    @(posedge clk); #1;
    check("b2b rdata2", rsp_rdata, 32'h12348000);
    rsp_count += rsp_valid;
    repeat (3) begin
      @(posedge clk); #1;
      rsp_count += rsp_valid;
    end
    check("b2b rsp count", rsp_count, 32'd2);

    // Reset during LOAD_WAIT drops the pending response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst mid ready pre", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst mid ready", {31'h0, req_ready}, 32'h1);
    rsp_count = 0;
    repeat (2) begin
      @(posedge clk); #1;
      rsp_count += rsp_valid;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      rsp_count += rsp_valid;
    end
    check("rst mid no rsp", rsp_count, 32'd0);
    check("rst mid ready post", {31'h0, req_ready}, 32'h1);
    access("lw after rst", 1'b0, 2'b10, 1'b0, 'h14, 32'h0, 4'h0, 32'h0, 1'b0, 32'h12348000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
